// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: round-robin arbiter driving the select lines of a 4:1 mux.
//
// A grant is held for DWELL cycles, or ends early on the cycle after the
// granted request is seen low. Arbitration starts at the input after the last
// granted one. Back-to-back grants have no idle cycle between them.
//
// Parameters
//   DWELL  grant hold length in cycles, 1..15 (default 4)
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   req    request per mux input (bit0=a .. bit3=d)
//   s0/s1  mux select, {s1,s0} = granted index
//   gnt    one-hot grant, 0000 when idle
//   busy   high while a grant is active
//   done   one-cycle pulse on the final grant cycle
//
// Build option
//   ARB_SELECT_PARK_EN  when defined, s1/s0 keep the last granted index while
//                       idle; otherwise they return to 00 on entering idle.
//
// Every output comes straight from a flop.
module mux_select_arbiter #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       s0,
  output logic       s1,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] DwellCnt = 4'(DWELL);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [1:0] ptr_q;  // last granted index; equals the current owner during a grant

  logic       win_valid;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Round-robin pick starting at ptr_q+1. Scan from the farthest candidate to
  // the nearest so the nearest requester overwrites the others.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt      <= 4'b0000;
      s1       <= 1'b0;
      s0       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt_q    <= 4'd0;
      ptr_q    <= 2'd3;
    end else begin
      // A new arbitration happens from idle or at the end of a grant
      // (done marks the final grant cycle).
      if (state_q == StIdle || done) begin
        if (win_valid) begin
          state_q  <= StGrant;
          gnt      <= 4'b0001 << win_idx;
          {s1, s0} <= win_idx;
          busy     <= 1'b1;
          cnt_q    <= 4'd1;
          done     <= (DwellCnt == 4'd1);
          ptr_q    <= win_idx;
        end else begin
          state_q  <= StIdle;
          gnt      <= 4'b0000;
          busy     <= 1'b0;
          done     <= 1'b0;
          cnt_q    <= 4'd0;
`ifdef ARB_SELECT_PARK_EN
          {s1, s0} <= {s1, s0};
`else
          {s1, s0} <= 2'b00;
`endif
        end
      end else begin
        // Mid-grant: only the owner's request bit matters. A low sample makes
        // the next cycle the final one.
        cnt_q <= cnt_q + 4'd1;
        done  <= ((cnt_q + 4'd1) == DwellCnt) || !req[ptr_q];
      end
    end
  end

endmodule
